conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 156 +++++++++++++++
 tb/tb_conv_window_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to Size x Size sliding windows.
// Optional WINGEN_FRAME_COUNT_EN enables the completed-frame counter.
module conv_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int Size       = 5,
  parameter int ImgW       = 32,
  parameter int ImgH       = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           pix_in,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  output logic [Size*Size*DATA_WIDTH-1:0] win_data,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [15:0]                     win_row,
  output logic [15:0]                     win_col,
  output logic                            frame_done,
  output logic [15:0]                     frame_count
);

  localparam int N  = (Size-1)*ImgW+Size;
  localparam int WW = Size*Size*DATA_WIDTH;

  localparam logic [15:0] LCOL = 16'(ImgW-1);
  localparam logic [15:0] LROW = 16'(ImgH-1);
  localparam logic [15:0] FROW = 16'(Size-2);
  localparam logic [15:0] EDGE = 16'(Size-1);
  localparam logic [15:0] LWR  = 16'(ImgH-Size);
  localparam logic [15:0] LWC  = 16'(ImgW-Size);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HOLD
  } state_t;

  state_t                state;
  logic [15:0]           col;
  logic [15:0]           row;
  logic [DATA_WIDTH-1:0] sr  [N];
  logic [DATA_WIDTH-1:0] nxt [N];
  logic [WW-1:0]         win_nxt;
  logic                  acc;
  logic                  last_col;

  assign acc      = pix_valid & pix_ready;
  assign last_col = (col == LCOL);

  // Shift register contents after accepting pix_in
  always_comb begin
    nxt[0] = pix_in;
    for (int k = 1; k < N; k++) begin
      nxt[k] = sr[k-1];
    end
  end

  // Window whose bottom-right pixel is the one being accepted
  always_comb begin
    win_nxt = '0;
    for (int r = 0; r < Size; r++) begin
      for (int c = 0; c < Size; c++) begin
        win_nxt[DATA_WIDTH*(r*Size+c) +: DATA_WIDTH] =
          nxt[(Size-1-r)*ImgW + (Size-1-c)];
      end
    end
  end

  // Line-buffer shift register, newest pixel at entry 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        sr[k] <= '0;
      end
    end else if (acc) begin
      sr <= nxt;
    end
  end

  // Raster position of the next pixel to arrive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (last_col) begin
        col <= '0;
        row <= (row == LROW) ? '0 : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // Fill / run / hold control with registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      pix_ready  <= 1'b1;
      win_valid  <= 1'b0;
      win_data   <= '0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        FILL: begin
          if (acc && last_col && row == FROW) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (acc && col >= EDGE) begin
            win_data  <= win_nxt;
            win_row   <= row - EDGE;
            win_col   <= col - EDGE;
            win_valid <= 1'b1;
            pix_ready <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            pix_ready <= 1'b1;
            if (win_row == LWR && win_col == LWC) begin
              frame_done <= 1'b1;
              state      <= FILL;
            end else begin
              state <= RUN;
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef WINGEN_FRAME_COUNT_EN
  // Completed frames, wrapping at 2^16
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed bench, Size=5 on an 8x8 image.
// Pixel value is row*8+col; windows are checked in order by a monitor.
module tb_conv_window_gen;

  localparam int DW = 16;
  localparam int SZ = 5;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int WPF = (IW-SZ+1)*(IH-SZ+1);

  logic                  clk;
  logic                  reset;
  logic [DW-1:0]         pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [SZ*SZ*DW-1:0]   win_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [15:0]           win_row;
  logic [15:0]           win_col;
  logic                  frame_done;
  logic [15:0]           frame_count;

  int total = 0;
  int bad   = 0;
  int widx  = 0;
  int nframes = 0;
  logic [SZ*SZ*DW-1:0] held;

  conv_window_gen #(
    .DATA_WIDTH(DW),
    .Size(SZ),
    .ImgW(IW),
    .ImgH(IH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_in(pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .win_data(win_data),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_row(win_row),
    .win_col(win_col),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fc_exp(input int n);
`ifdef WINGEN_FRAME_COUNT_EN
    return 16'(n);
`else
    return 16'd0 + 16'(n * 0);
`endif
  endfunction

  function automatic logic [15:0] elem(input int i);
    return win_data[DW*i +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    logic rdy;
    int n;
    n = 0;
    pix_in = 16'(v);
    pix_valid = 1'b1;
    forever begin
      rdy = pix_ready;
      step();
      if (rdy) break;
      n++;
      if (n > 50) begin
        check("pix_ready_timeout", pix_ready, 1);
        break;
      end
    end
  endtask

  task automatic send_frame(input bit gaps, input int last);
    for (int v = 0; v <= last; v++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        pix_valid = 1'b0;
        step();
      end
      send(v);
    end
    pix_valid = 1'b0;
  endtask

  // Scoreboard: every accepted window must match the raster model
  always @(negedge clk) begin
    if (!reset) begin
      widx = 0;
    end else begin
      if (win_valid && win_ready) begin
        check("win_row", win_row, widx / (IW-SZ+1));
        check("win_col", win_col, widx % (IW-SZ+1));
        for (int r = 0; r < SZ; r++) begin
          for (int c = 0; c < SZ; c++) begin
            check($sformatf("w%0d_e%0d", widx, r*SZ+c),
                  elem(r*SZ+c),
                  ((widx/(IW-SZ+1))+r)*IW + (widx%(IW-SZ+1))+c);
          end
        end
        widx++;
      end
      if (frame_done) begin
        check("frame_end_idx", widx, WPF);
        widx = 0;
        nframes++;
      end
    end
  end

  initial begin
    reset = 1'b0;
    pix_in = '0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    repeat (3) step();
    check("rst_win_valid", win_valid, 0);
    check("rst_pix_ready", pix_ready, 1);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_win_data", win_data == '0, 1);
    reset = 1'b1;
    step();

    // First window, held with win_ready low
    for (int v = 0; v < 36; v++) send(v);
    check("pre_win_valid", win_valid, 0);
    send(36);
    check("w0_valid", win_valid, 1);
    check("w0_pix_ready", pix_ready, 0);
    check("w0_e0", elem(0), 0);
    check("w0_e4", elem(4), 4);
    check("w0_e20", elem(20), 32);
    check("w0_e24", elem(24), 36);
    check("w0_row", win_row, 0);
    check("w0_col", win_col, 0);

    held = win_data;
    pix_in = 16'd37;
    pix_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_pix_ready", pix_ready, 0);
      check("hold_win_valid", win_valid, 1);
      check("hold_data", win_data == held, 1);
    end
    win_ready = 1'b1;
    step();
    check("rel_win_valid", win_valid, 0);
    check("rel_pix_ready", pix_ready, 1);
    for (int v = 37; v < IW*IH; v++) send(v);
    pix_valid = 1'b0;
    repeat (4) step();
    check("frames_1", nframes, 1);
    check("frame_count_1", frame_count, fc_exp(1));
    check("idle_frame_done", frame_done, 0);

    // Back-to-back continuous frame
    send_frame(1'b0, IW*IH-1);
    repeat (4) step();
    check("frames_2", nframes, 2);
    check("frame_count_2", frame_count, fc_exp(2));

    // Frame with random input gaps
    send_frame(1'b1, IW*IH-1);
    repeat (4) step();
    check("frames_3", nframes, 3);
    check("frame_count_3", frame_count, fc_exp(3));

    // Reset while window (1,2) is pending
    send_frame(1'b0, 45);
    step();
    win_ready = 1'b0;
    send(46);
    pix_valid = 1'b0;
    check("pend_valid", win_valid, 1);
    check("pend_row", win_row, 1);
    check("pend_col", win_col, 2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_win_valid", win_valid, 0);
    check("arst_frame_count", frame_count, 0);
    check("arst_pix_ready", pix_ready, 1);
    step();
    reset = 1'b1;
    nframes = 0;
    win_ready = 1'b1;
    step();
    for (int v = 0; v < 36; v++) send(v);
    win_ready = 1'b0;
    send(36);
    check("post_row", win_row, 0);
    check("post_col", win_col, 0);
    check("post_e24", elem(24), 36);
    win_ready = 1'b1;
    for (int v = 37; v < IW*IH; v++) send(v);
    pix_valid = 1'b0;
    repeat (4) step();
    check("frames_post", nframes, 1);
    check("frame_count_post", frame_count, fc_exp(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
